// File: rtl/ex_stage_pkg.sv
// ----------------------------------------------------------------------------
// ex_stage_pkg
// Shared encodings for the execute stage: word width, reset/stall/write-enable
// levels, operation class (alusel) and per-class operation (aluop) codes, the
// multiplier FSM state type and a shift-amount helper.
// ----------------------------------------------------------------------------
package ex_stage_pkg;

    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 4;

    // Reset is active-low; stall and write enable are active-high.
    localparam logic RST_ENABLE    = 1'b0;
    localparam logic STALL_YES     = 1'b1;
    localparam logic STALL_NO      = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // Operation classes (alusel). Codes 5-7 are unused and behave as NOP.
    localparam logic [2:0] SEL_NOP   = 3'd0;
    localparam logic [2:0] SEL_LOGIC = 3'd1;
    localparam logic [2:0] SEL_SHIFT = 3'd2;
    localparam logic [2:0] SEL_ARITH = 3'd3;
    localparam logic [2:0] SEL_MUL   = 3'd4;

    // LOGIC class operations
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_MOVE = 3'd4;

    // SHIFT class operations
    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;

    // ARITH class operations
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_SLT  = 3'd2;
    localparam logic [2:0] OP_SLTU = 3'd3;
    localparam logic [2:0] OP_NEG  = 3'd4;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // A raw shift amount of zero encodes a shift by eight.
    function automatic logic [3:0] shift_amount(input logic [3:0] raw);
        return (raw == 4'd0) ? 4'd8 : raw;
    endfunction

endpackage

// File: rtl/ex_mul.sv
// ----------------------------------------------------------------------------
// ex_mul
// Sequential 16x16 shift-add multiplier returning the low 16 bits of a*b.
// A start seen in IDLE latches the operands; sixteen BUSY cycles each do one
// shift-add step; one DONE cycle presents the product, then the unit returns
// to IDLE regardless of start.
//
// Ports
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   start   : request a multiply (only acted on in IDLE)
//   a, b    : operands, sampled only on the IDLE->BUSY edge
//   busy    : registered, high during the sixteen step cycles
//   done    : registered, high for the single result cycle
//   product : low 16 bits of a*b, valid while done is high
// ----------------------------------------------------------------------------
module ex_mul
    import ex_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] product
);

    mul_state_e        state_r;
    logic [3:0]        cnt_r;
    logic [WORD_W-1:0] mcand_r;   // multiplicand, shifted left each step
    logic [WORD_W-1:0] mplier_r;  // multiplier, shifted right each step
    logic [WORD_W-1:0] prod_r;
    logic              busy_r;
    logic              done_r;

    // Multiplier FSM: operand latch, shift-add datapath and registered handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_r  <= MUL_IDLE;
            cnt_r    <= 4'd0;
            mcand_r  <= 16'd0;
            mplier_r <= 16'd0;
            prod_r   <= 16'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                MUL_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        mcand_r  <= a;
                        mplier_r <= b;
                        prod_r   <= 16'd0;
                        cnt_r    <= 4'd0;
                        busy_r   <= 1'b1;
                        state_r  <= MUL_BUSY;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                MUL_BUSY: begin
                    // Bits shifted past bit 15 never reach the low half of the product.
                    if (mplier_r[0]) begin
                        prod_r <= prod_r + mcand_r;
                    end else begin
                        prod_r <= prod_r;
                    end
                    mcand_r  <= {mcand_r[14:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[15:1]};
                    cnt_r    <= cnt_r + 4'd1;
                    if (cnt_r == 4'd15) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= MUL_DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                MUL_DONE: begin
                    // The instruction is still held here; it must not restart.
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= MUL_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= MUL_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = prod_r;

endmodule

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage
// Execute stage of a 16-bit pipeline. LOGIC, SHIFT and ARITH classes resolve
// combinationally in the same cycle; MUL is delegated to ex_mul and stalls
// the front of the pipeline for 17 cycles before a single result cycle.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   aluop    : operation within class
//   alusel   : operation class (NOP/LOGIC/SHIFT/ARITH/MUL, 5-7 = NOP)
//   reg0     : operand A
//   reg1     : operand B
//   waddr    : destination register
//   we       : write enable
//   wdata_o  : result to ex_mem
//   waddr_o  : destination passed through
//   we_o     : write enable to ex_mem (forced low while stalling)
//   stallreq : hold request for pc/if_id/id_ex
// ----------------------------------------------------------------------------
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            aluop,
    input  logic [2:0]            alusel,
    input  logic [WORD_W-1:0]     reg0,
    input  logic [WORD_W-1:0]     reg1,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic                  we,
    output logic [WORD_W-1:0]     wdata_o,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic                  we_o,
    output logic                  stallreq
);

    logic              mul_start_s;
    logic              mul_busy_s;
    logic              mul_done_s;
    logic [WORD_W-1:0] mul_product_s;
    logic              stall_s;
    logic [3:0]        sh_s;
    logic [WORD_W-1:0] logic_res_s;
    logic [WORD_W-1:0] shift_res_s;
    logic [WORD_W-1:0] arith_res_s;
    logic [WORD_W-1:0] wdata_s;
    logic              we_s;

    assign mul_start_s = (alusel == SEL_MUL);

    ex_mul u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .a       (reg0),
        .b       (reg1),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Stall request: a MUL waiting in IDLE, or the multiplier stepping.
    always_comb begin
        stall_s = STALL_NO;
        if (mul_busy_s) begin
            stall_s = STALL_YES;
        end else if (!mul_done_s && mul_start_s) begin
            stall_s = STALL_YES;
        end else begin
            stall_s = STALL_NO;
        end
    end

    // LOGIC class result.
    always_comb begin
        logic_res_s = 16'd0;
        case (aluop)
            OP_AND:  logic_res_s = reg0 & reg1;
            OP_OR:   logic_res_s = reg0 | reg1;
            OP_XOR:  logic_res_s = reg0 ^ reg1;
            OP_NOT:  logic_res_s = ~reg0;
            OP_MOVE: logic_res_s = reg0;
            default: logic_res_s = 16'd0;
        endcase
    end

    assign sh_s = shift_amount(reg1[3:0]);

    // SHIFT class result; the amount is always 1..15 so the rotate never wraps to 16.
    always_comb begin
        shift_res_s = 16'd0;
        case (aluop)
            OP_SLL:  shift_res_s = reg0 << sh_s;
            OP_SRL:  shift_res_s = reg0 >> sh_s;
            OP_SRA:  shift_res_s = $signed(reg0) >>> sh_s;
            OP_ROL:  shift_res_s = (reg0 << sh_s) | (reg0 >> (5'd16 - {1'b0, sh_s}));
            default: shift_res_s = 16'd0;
        endcase
    end

    // ARITH class result, all modulo 2^16.
    always_comb begin
        arith_res_s = 16'd0;
        case (aluop)
            OP_ADD:  arith_res_s = reg0 + reg1;
            OP_SUB:  arith_res_s = reg0 - reg1;
            OP_SLT:  arith_res_s = {15'd0, ($signed(reg0) < $signed(reg1))};
            OP_SLTU: arith_res_s = {15'd0, (reg0 < reg1)};
            OP_NEG:  arith_res_s = 16'd0 - reg0;
            default: arith_res_s = 16'd0;
        endcase
    end

    // Result mux: DONE cycle shows the product; stalls write nothing.
    always_comb begin
        wdata_s = 16'd0;
        we_s    = WRITE_DISABLE;
        if (mul_done_s) begin
            wdata_s = mul_product_s;
            we_s    = we;
        end else if (stall_s == STALL_YES) begin
            wdata_s = 16'd0;
            we_s    = WRITE_DISABLE;
        end else begin
            case (alusel)
                SEL_LOGIC: begin
                    wdata_s = logic_res_s;
                    we_s    = we;
                end
                SEL_SHIFT: begin
                    wdata_s = shift_res_s;
                    we_s    = we;
                end
                SEL_ARITH: begin
                    wdata_s = arith_res_s;
                    we_s    = we;
                end
                default: begin
                    wdata_s = 16'd0;
                    we_s    = WRITE_DISABLE;
                end
            endcase
        end
    end

    // Output drive; everything reads zero while reset is held.
    always_comb begin
        wdata_o  = 16'd0;
        waddr_o  = 4'd0;
        we_o     = WRITE_DISABLE;
        stallreq = STALL_NO;
        if (rst == RST_ENABLE) begin
            wdata_o  = 16'd0;
            waddr_o  = 4'd0;
            we_o     = WRITE_DISABLE;
            stallreq = STALL_NO;
        end else begin
            wdata_o  = wdata_s;
            waddr_o  = waddr;
            we_o     = we_s;
            stallreq = stall_s;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic [2:0]  aluop;
    logic [2:0]  alusel;
    logic [15:0] reg0;
    logic [15:0] reg1;
    logic [3:0]  waddr;
    logic        we;
    logic [15:0] wdata_o;
    logic [3:0]  waddr_o;
    logic        we_o;
    logic        stallreq;

    int vec_cnt = 0;
    int err_cnt = 0;

    ex_stage dut (
        .clk      (clk),
        .rst      (rst),
        .aluop    (aluop),
        .alusel   (alusel),
        .reg0     (reg0),
        .reg1     (reg1),
        .waddr    (waddr),
        .we       (we),
        .wdata_o  (wdata_o),
        .waddr_o  (waddr_o),
        .we_o     (we_o),
        .stallreq (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [2:0] sel, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] wa, input logic w);
        alusel = sel; aluop = op; reg0 = a; reg1 = b; waddr = wa; we = w;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(3'd3, 3'd0, 16'h1234, 16'h0001, 4'd9, 1'b1);
        #2;
        vec_cnt++;
        if (wdata_o !== 16'h0000 || waddr_o !== 4'd0 || we_o !== 1'b0 || stallreq !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got wdata=%h waddr=%h we=%b stall=%b, want 0/0/0/0",
                     wdata_o, waddr_o, we_o, stallreq);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_arith();
        logic [2:0]  op_t   [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        logic [15:0] a_t    [6] = '{16'h7FFF, 16'h0005, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000};
        logic [15:0] b_t    [6] = '{16'h0001, 16'h0007, 16'h0001, 16'h0001, 16'h0000, 16'h0001};
        logic [15:0] exp_t  [6] = '{16'h8000, 16'hFFFE, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFF};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(3'd3, op_t[i], a_t[i], b_t[i], 4'd3, 1'b1);
            #2;
            vec_cnt++;
            if (wdata_o !== exp_t[i] || waddr_o !== 4'd3 || we_o !== 1'b1 || stallreq !== 1'b0) begin
                err_cnt++;
                $display("FAIL arith_%0d: got wdata=%h waddr=%h we=%b stall=%b, want %h/3/1/0",
                         i, wdata_o, waddr_o, we_o, stallreq, exp_t[i]);
            end
        end
    endtask

    task automatic test_shift_logic();
        logic [2:0]  sel_t [10] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        logic [2:0]  op_t  [10] = '{3'd2, 3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        logic [15:0] a_t   [10] = '{16'h8000, 16'h0001, 16'h8000, 16'h8001, 16'hF0F0,
                                    16'h00F0, 16'hFF00, 16'h00FF, 16'hABCD, 16'hFFFF};
        logic [15:0] b_t   [10] = '{16'h0000, 16'h0004, 16'h000F, 16'h0001, 16'hFF00,
                                    16'h0F00, 16'h0FF0, 16'h1234, 16'h1234, 16'hFFFF};
        logic [15:0] exp_t [10] = '{16'hFF80, 16'h0010, 16'h0001, 16'h0003, 16'hF000,
                                    16'h0FF0, 16'hF0F0, 16'hFF00, 16'hABCD, 16'h0000};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(sel_t[i], op_t[i], a_t[i], b_t[i], 4'd7, 1'b1);
            #2;
            vec_cnt++;
            if (wdata_o !== exp_t[i] || waddr_o !== 4'd7 || we_o !== 1'b1 || stallreq !== 1'b0) begin
                err_cnt++;
                $display("FAIL shift_logic_%0d: got wdata=%h waddr=%h we=%b stall=%b, want %h/7/1/0",
                         i, wdata_o, waddr_o, we_o, stallreq, exp_t[i]);
            end
        end
    endtask

    task automatic test_nop();
        logic [2:0] sel_t [3] = '{3'd0, 3'd5, 3'd7};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(sel_t[i], 3'd0, 16'h5555, 16'h3333, 4'd2, 1'b1);
            #2;
            vec_cnt++;
            if (wdata_o !== 16'h0000 || we_o !== 1'b0 || waddr_o !== 4'd2 || stallreq !== 1'b0) begin
                err_cnt++;
                $display("FAIL nop_sel%0d: got wdata=%h we=%b waddr=%h stall=%b, want 0/0/2/0",
                         sel_t[i], wdata_o, we_o, waddr_o, stallreq);
            end
        end
    endtask

    task automatic test_mul(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] expv, input bit perturb, input string nm);
        @(negedge clk);
        drive(3'd4, 3'd0, a, b, 4'd4, 1'b1);
        for (int c = 0; c < 17; c++) begin
            if (c > 0) @(negedge clk);
            if (perturb && c == 3) begin
                reg0 = 16'h1234; reg1 = 16'h00FF; we = 1'b1;
            end
            #2;
            vec_cnt++;
            if (stallreq !== 1'b1 || we_o !== 1'b0) begin
                err_cnt++;
                $display("FAIL %s_stall_c%0d: got stall=%b we=%b, want 1/0", nm, c, stallreq, we_o);
            end
        end
        @(negedge clk);
        #2;
        vec_cnt++;
        if (stallreq !== 1'b0 || we_o !== 1'b1 || wdata_o !== expv) begin
            err_cnt++;
            $display("FAIL %s_result: got stall=%b we=%b wdata=%h, want 0/1/%h",
                     nm, stallreq, we_o, wdata_o, expv);
        end
    endtask

    task automatic test_mul_basic();
        test_mul(16'd300, 16'd300, 16'h5F90, 1'b0, "mul300");
        @(negedge clk);
        drive(3'd0, 3'd0, 16'h0000, 16'h0000, 4'd0, 1'b0);
        #2;
        vec_cnt++;
        if (stallreq !== 1'b0) begin
            err_cnt++;
            $display("FAIL mul300_after: got stall=%b, want 0", stallreq);
        end
    endtask

    task automatic test_mul_input_change();
        test_mul(16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, "mulffff");
        @(negedge clk);
        drive(3'd0, 3'd0, 16'h0000, 16'h0000, 4'd0, 1'b0);
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk);
        drive(3'd4, 3'd0, 16'd300, 16'd300, 4'd5, 1'b1);
        repeat (8) @(posedge clk);   // IDLE->BUSY edge plus 7 BUSY steps
        #2;
        rst = 1'b0;
        #1;
        vec_cnt++;
        if (wdata_o !== 16'h0000 || waddr_o !== 4'd0 || we_o !== 1'b0 || stallreq !== 1'b0) begin
            err_cnt++;
            $display("FAIL midmul_reset: got wdata=%h waddr=%h we=%b stall=%b, want 0/0/0/0",
                     wdata_o, waddr_o, we_o, stallreq);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(3'd1, 3'd1, 16'h00F0, 16'h0F00, 4'd6, 1'b1);
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            #2;
            vec_cnt++;
            if (wdata_o !== 16'h0FF0 || we_o !== 1'b1 || stallreq !== 1'b0 || waddr_o !== 4'd6) begin
                err_cnt++;
                $display("FAIL post_reset_or_%0d: got wdata=%h we=%b stall=%b waddr=%h, want 0ff0/1/0/6",
                         c, wdata_o, we_o, stallreq, waddr_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_mul(16'd3, 16'd5, 16'd15, 1'b0, "b2b_first");
        test_mul(16'd7, 16'd9, 16'd63, 1'b0, "b2b_second");
        @(negedge clk);
        drive(3'd0, 3'd0, 16'h0000, 16'h0000, 4'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #2;
            vec_cnt++;
            if (stallreq !== 1'b0 || we_o !== 1'b0) begin
                err_cnt++;
                $display("FAIL b2b_no_third_%0d: got stall=%b we=%b, want 0/0", c, stallreq, we_o);
            end
        end
    endtask

    initial begin
        drive(3'd0, 3'd0, 16'h0000, 16'h0000, 4'd0, 1'b0);
        rst = 1'b1;
        test_reset();
        test_arith();
        test_shift_logic();
        test_nop();
        test_mul_basic();
        test_mul_input_change();
        test_reset_mid_mul();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low (`RstEnable = 1'b0).
REQ-003 SHALL have port: aluop  input  3  operation within class, from id_ex ex_aluop.
REQ-004 SHALL have port: alusel  input  3  operation class, from id_ex ex_alusel.
REQ-005 SHALL have port: reg0  input  16  operand A.
REQ-006 SHALL have port: reg1  input  16  operand B.
REQ-007 SHALL have port: waddr  input  4  destination register.
REQ-008 SHALL have port: we  input  1  write enable (`WriteEnable = 1).
REQ-009 SHALL have port: wdata_o  output  16  result to ex_mem.
REQ-010 SHALL have port: waddr_o  output  4  destination passed through.
REQ-011 SHALL have port: we_o  output  1  write enable to ex_mem.
REQ-012 SHALL have port: stallreq  output  1  request to hold pc/if_id/id_ex (`StallYes = 1).

Function
REQ-013 SHALL decode alusel: 0 NOP, 1 LOGIC, 2 SHIFT, 3 ARITH, 4 MUL; 5-7 treated as NOP.
REQ-014 SHALL, for LOGIC, compute combinationally: aluop 0 AND, 1 OR, 2 XOR, 3 NOT reg0, 4 MOVE reg0; others 0.
REQ-015 SHALL, for SHIFT, use shift amount reg1[3:0], with amount 0 meaning 8: aluop 0 SLL, 1 SRL, 2 SRA, 3 ROL.
REQ-016 SHALL, for ARITH, compute mod 2^16: aluop 0 ADD, 1 SUB (reg0-reg1), 2 SLT signed (1/0), 3 SLTU unsigned (1/0), 4 NEG.
REQ-017 SHALL give NOP wdata_o=0, we_o=0.
REQ-018 SHALL drive waddr_o=waddr and, for single-cycle classes, we_o=we, with zero-cycle latency and stallreq=0.
REQ-019 SHALL implement MUL as a 3-state FSM IDLE/BUSY/DONE producing the low 16 bits of reg0*reg1 (unsigned; equals signed low half).
REQ-020 SHALL, in IDLE with alusel=MUL, assert stallreq combinationally, latch reg0/reg1, clear the 4-bit counter, and go to BUSY.
REQ-021 SHALL, in BUSY, perform one shift-add step per cycle, keep stallreq=1, increment the counter, and go to DONE after count 15 (16 BUSY cycles).
REQ-022 SHALL, in DONE, drive stallreq=0, wdata_o=product, we_o=we, then return to IDLE unconditionally.
REQ-023 SHALL keep a MUL occupying exactly 18 cycles: 17 with stallreq=1, then 1 result cycle.
REQ-024 SHALL force we_o=0 whenever stallreq=1, so no partial result is written.
REQ-025 SHALL not restart on the held MUL in DONE; a back-to-back MUL is accepted only from IDLE on the following cycle.
REQ-026 SHALL ignore input changes during BUSY, since operands come from the latched copy.

Reset
REQ-027 SHALL, on rst low at any time including mid-MUL, asynchronously force state=IDLE, counter=0, product/latches=0.
REQ-028 SHALL, while rst is low, drive wdata_o=0, waddr_o=0, we_o=0, stallreq=0.
REQ-029 SHALL, after rst rises, treat the first edge as IDLE; an aborted MUL is not resumed.

Structure
REQ-030 SHALL take alusel/aluop encodings, `RstEnable, `StallYes/`StallNo, `WriteEnable/`WriteDisable and the 16-bit word width from the shared defines.v.
REQ-031 SHALL place the shift-add multiplier, with start/busy/done handshake, in sub-module ex_mul; ALU and output mux stay in ex_stage.

Verification
REQ-032 SHALL cover: ARITH ADD, reg0=16'h7FFF, reg1=1, waddr=3, we=1 -> same cycle wdata_o=16'h8000, waddr_o=3, we_o=1, stallreq=0.
REQ-033 SHALL cover: SHIFT SRA, reg0=16'h8000, reg1=0 -> wdata_o=16'hFF80 (shift 8); SLT reg0=16'hFFFF, reg1=1 -> 1; SLTU -> 0.
REQ-034 SHALL cover: MUL reg0=300, reg1=300, we=1 -> stallreq=1 for 17 cycles with we_o=0, then one cycle wdata_o=16'h5F90 (90000 mod 65536), we_o=1, stallreq=0.
REQ-035 SHALL cover: MUL 16'hFFFF*16'hFFFF, with inputs changed during BUSY -> result 16'h0001 unaffected.
REQ-036 SHALL cover: rst low at BUSY cycle 7 -> outputs 0 immediately; after release a single-cycle OR 16'h00F0|16'h0F00 -> 16'h0FF0, stallreq=0.
REQ-037 SHALL cover: two back-to-back MULs (3*5 then 7*9) -> results 15 then 63, each after its own 17 stall cycles, no third start.
